regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file.
- Successor to the current single-write register bank; sits between decode (read addresses) and writeback (write ports) in the CPU datapath.
- Adds:
  - a second write port with fixed priority
  - optional write-to-read bypass
  - a per-register busy scoreboard for hazard detection
  - a sequential clear sweep, usable without asserting reset

Parameters:
- DW, 32, data width in bits
- DEPTH, 16, number of architectural registers (2..2^AW); register 0 is hardwired to zero
- AW, 5, address width
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = reads return stored contents only

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST_N  input  1  asynchronous active-low reset
- RA0  input  AW  read address, port 0
- RA1  input  AW  read address, port 1
- RD0  output  DW  read data, port 0 (combinational)
- RD1  output  DW  read data, port 1 (combinational)
- WE0  input  1  write enable, port 0
- WA0  input  AW  write address, port 0
- WD0  input  DW  write data, port 0
- WE1  input  1  write enable, port 1 (priority port)
- WA1  input  AW  write address, port 1
- WD1  input  DW  write data, port 1
- ISSUE_EN  input  1  mark destination register busy
- ISSUE_RA  input  AW  destination register to mark busy
- BUSY0  output  1  scoreboard bit of RA0 (combinational)
- BUSY1  output  1  scoreboard bit of RA1 (combinational)
- CLR_REQ  input  1  start clear sweep (sampled at clock edge)
- CLR_BUSY  output  1  high while sweep in progress

Behaviour:
- Reset is asynchronous and active-low: one clock CLK; RST_N low immediately forces:
  - all registers to 0
  - all busy bits to 0
  - FSM to IDLE
  - CLR_BUSY to 0
- Reset release is synchronous to CLK. Asserting RST_N mid-sweep aborts the sweep.
- Reads:
  - Combinational, zero latency.
  - RA == 0 or RA >= DEPTH -> RD = 0.
  - Otherwise RD = stored register value.
- Bypass (BYPASS = 1, FSM IDLE only):
  - If WE1 and WA1 == RA, RD = WD1.
  - Else if WE0 and WA0 == RA, RD = WD0.
  - Never applies to address 0 or to RA >= DEPTH.
- Writes:
  - Register updated on the rising edge when WE is high.
  - Address 0 or address >= DEPTH: write ignored.
  - WE0 and WE1 to the same address in the same cycle: WD1 stored, WD0 discarded.
  - Writes to different addresses both commit.
- Scoreboard, one bit per register:
  - Bit 0 is always 0.
  - Write commit (either port) clears the written register's bit.
  - ISSUE_EN sets bit[ISSUE_RA] at the edge.
  - Issue and write to the same register in the same cycle: bit ends set (the new producer wins).
  - ISSUE_RA of 0 or >= DEPTH is ignored.
  - BUSY0/BUSY1 reflect the current bit with no bypass: a register written in the current cycle still reads busy until the edge.
- Clear FSM, two states:
  - IDLE: CLR_REQ = 1 at the edge -> SWEEP with ptr = 1; CLR_BUSY goes high the following cycle.
  - SWEEP, each cycle:
    - r[ptr] <= 0 and busy[ptr] <= 0
    - ptr increments
    - when ptr == DEPTH-1 is cleared -> IDLE
  - Duration: exactly DEPTH-1 cycles with CLR_BUSY high. Registers not yet swept keep their values and remain readable.
  - During SWEEP:
    - WE0, WE1, ISSUE_EN and CLR_REQ are ignored.
    - Bypass is disabled.
    - Reads return array contents.
  - CLR_REQ together with writes in IDLE: writes commit at that edge, and the sweep then zeroes them.
- The pointer counter is AW bits wide and never wraps: termination is at DEPTH-1, including the DEPTH = 2^AW case.

Test Plan:
1. Async reset mid-cycle: set r3 = 0xDEADBEEF, drop RST_N between edges -> RD0 (RA0 = 3) reads 0 immediately; BUSY0 = 0; CLR_BUSY = 0.
2. Dual write, same address: WE0/WA0 = 5/WD0 = 0x11 and WE1/WA1 = 5/WD1 = 0x22 -> before the edge RD0 (RA0 = 5) = 0x22 via bypass; after the edge r5 = 0x22. Rerun with BYPASS = 0: before the edge RD0 = old r5.
3. Zero and out-of-range: write 0x55 to addresses 0 and 16 (DEPTH = 16) -> RD at RA = 0 and RA = 16 reads 0; no register changes.
4. Scoreboard: ISSUE_RA = 7 -> BUSY1 (RA1 = 7) = 1 next cycle. Then WE0 to 7 together with ISSUE_RA = 7 -> BUSY1 stays 1. Then WE1 to 7 alone -> BUSY1 = 0.
5. Clear sweep: fill r1..r15 with i*0x100, assert CLR_REQ for one cycle -> CLR_BUSY high exactly 15 cycles. On the cycle after the k-th sweep edge, r(k+1) still reads its original value. A WE0 to r2 during the sweep is ignored. Afterwards all registers read 0 and all busy bits are 0.
6. Reset mid-sweep: assert RST_N low at sweep cycle 4 -> CLR_BUSY drops immediately; all registers read 0. After release, a write to r9 = 0x9 commits normally.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port general-purpose register file.
// Two combinational read ports, two write ports (port 1 has priority),
// optional same-cycle write-to-read forwarding, a per-register busy
// scoreboard and a sequential clear sweep that runs without reset.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | normal operation: writes, issues and bypass are active
// SWEEP | zeroing r[ptr]/busy[ptr] one register per cycle, 1..DEPTH-1
module regfile_mp #(
  parameter int DW     = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [AW-1:0] RA0,
  input  logic [AW-1:0] RA1,
  output logic [DW-1:0] RD0,
  output logic [DW-1:0] RD1,
  input  logic          WE0,
  input  logic [AW-1:0] WA0,
  input  logic [DW-1:0] WD0,
  input  logic          WE1,
  input  logic [AW-1:0] WA1,
  input  logic [DW-1:0] WD1,
  input  logic          ISSUE_EN,
  input  logic [AW-1:0] ISSUE_RA,
  output logic          BUSY0,
  output logic          BUSY1,
  input  logic          CLR_REQ,
  output logic          CLR_BUSY
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // Last register the sweep touches; the pointer stops here and never wraps,
  // which keeps DEPTH == 2**AW safe.
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  state_t           state_q;
  state_t           state_d;
  logic [AW-1:0]    ptr_q;
  logic [AW-1:0]    ptr_d;
  logic             clr_busy_q;
  logic             clr_busy_d;

  logic [DW-1:0]    rd0_c;
  logic [DW-1:0]    rd1_c;
  logic             busy0_c;
  logic             busy1_c;
  logic             hit0;
  logic             hit1;

  // Read port 0: array lookup, then forwarding from the write ports when idle.
  // Address 0 and addresses beyond DEPTH never hit, so they read 0.
  always_comb begin
    rd0_c   = '0;
    busy0_c = 1'b0;
    hit0    = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if (RA0 == AW'(i)) begin
        rd0_c   = mem_q[i];
        busy0_c = busy_q[i];
        hit0    = 1'b1;
      end
    end
    if ((BYPASS != 0) && (state_q == IDLE) && hit0) begin
      if (WE1 && (WA1 == RA0)) begin
        rd0_c = WD1;
      end else if (WE0 && (WA0 == RA0)) begin
        rd0_c = WD0;
      end
    end
  end

  // Read port 1: same structure as port 0.
  always_comb begin
    rd1_c   = '0;
    busy1_c = 1'b0;
    hit1    = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if (RA1 == AW'(i)) begin
        rd1_c   = mem_q[i];
        busy1_c = busy_q[i];
        hit1    = 1'b1;
      end
    end
    if ((BYPASS != 0) && (state_q == IDLE) && hit1) begin
      if (WE1 && (WA1 == RA1)) begin
        rd1_c = WD1;
      end else if (WE0 && (WA0 == RA1)) begin
        rd1_c = WD0;
      end
    end
  end

  assign RD0      = rd0_c;
  assign RD1      = rd1_c;
  assign BUSY0    = busy0_c;
  assign BUSY1    = busy1_c;
  assign CLR_BUSY = clr_busy_q;

  // Next array and scoreboard contents. Port 1 is applied after port 0 so it
  // wins on a shared address; an issue is applied last so a new producer
  // keeps the register busy even when an older result lands the same cycle.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (state_q == IDLE) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (WE0 && (WA0 == AW'(i))) begin
          mem_d[i]  = WD0;
          busy_d[i] = 1'b0;
        end
        if (WE1 && (WA1 == AW'(i))) begin
          mem_d[i]  = WD1;
          busy_d[i] = 1'b0;
        end
        if (ISSUE_EN && (ISSUE_RA == AW'(i))) begin
          busy_d[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (ptr_q == AW'(i)) begin
          mem_d[i]  = '0;
          busy_d[i] = 1'b0;
        end
      end
    end
    mem_d[0]  = '0;
    busy_d[0] = 1'b0;
  end

  // Clear-sweep sequencing: next state, pointer and the registered busy flag.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_busy_d = clr_busy_q;
    case (state_q)
      IDLE: begin
        if (CLR_REQ) begin
          state_d    = SWEEP;
          ptr_d      = AW'(1);
          clr_busy_d = 1'b1;
        end
      end
      SWEEP: begin
        if (ptr_q == LAST_PTR) begin
          state_d    = IDLE;
          ptr_d      = '0;
          clr_busy_d = 1'b0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        ptr_d      = '0;
        clr_busy_d = 1'b0;
      end
    endcase
  end

  // Clear FSM state register with its registered CLR_BUSY output.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_busy_q <= clr_busy_d;
    end
  end

  // Register array and scoreboard storage.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with forwarding, one without,
// sharing all inputs. Table of single-cycle vectors plus hand sequences for
// async reset, the clear sweep and reset during a sweep.
module tb_regfile_mp;

  logic        CLK;
  logic        RST_N;
  logic [4:0]  ra0, ra1, wa0, wa1, iss_ra;
  logic [31:0] wd0, wd1;
  logic        we0, we1, iss_en, clr_req;

  logic [31:0] rd0_b, rd1_b, rd0_n, rd1_n;
  logic        busy0_b, busy1_b, busy0_n, busy1_n, clrb_b, clrb_n;

  int n_cmp;
  int n_bad;
  int cnt;

  regfile_mp #(.DW(32), .DEPTH(16), .AW(5), .BYPASS(1)) u_byp (
    .CLK(CLK), .RST_N(RST_N), .RA0(ra0), .RA1(ra1), .RD0(rd0_b), .RD1(rd1_b),
    .WE0(we0), .WA0(wa0), .WD0(wd0), .WE1(we1), .WA1(wa1), .WD1(wd1),
    .ISSUE_EN(iss_en), .ISSUE_RA(iss_ra), .BUSY0(busy0_b), .BUSY1(busy1_b),
    .CLR_REQ(clr_req), .CLR_BUSY(clrb_b)
  );

  regfile_mp #(.DW(32), .DEPTH(16), .AW(5), .BYPASS(0)) u_nob (
    .CLK(CLK), .RST_N(RST_N), .RA0(ra0), .RA1(ra1), .RD0(rd0_n), .RD1(rd1_n),
    .WE0(we0), .WA0(wa0), .WD0(wd0), .WE1(we1), .WA1(wa1), .WD1(wd1),
    .ISSUE_EN(iss_en), .ISSUE_RA(iss_ra), .BUSY0(busy0_n), .BUSY1(busy1_n),
    .CLR_REQ(clr_req), .CLR_BUSY(clrb_n)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iss;
    logic [4:0]  isa;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [31:0] e_rd0n;
    logic [31:0] e_rd1n;
    logic        e_b0;
    logic        e_b1;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_in();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    iss_en = 1'b0; iss_ra = '0; clr_req = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //         we0 wa0 wd0           we1 wa1 wd1        iss isa ra0 ra1 rd0           rd1           rd0n  rd1n          b0 b1
    vecs[0]  = '{1, 3, 32'hDEADBEEF, 0, 0,  32'h0,     0, 0, 3, 0, 32'hDEADBEEF, 32'h0,        32'h0, 32'h0,        0, 0};
    vecs[1]  = '{1, 5, 32'h11,       1, 5,  32'h22,    0, 0, 5, 3, 32'h22,       32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 0, 0};
    vecs[2]  = '{0, 0, 32'h0,        0, 0,  32'h0,     0, 0, 5, 3, 32'h22,       32'hDEADBEEF, 32'h22, 32'hDEADBEEF, 0, 0};
    vecs[3]  = '{1, 0, 32'h55,       1, 16, 32'h55,    0, 0, 0, 16, 32'h0,       32'h0,        32'h0, 32'h0,        0, 0};
    vecs[4]  = '{0, 0, 32'h0,        0, 0,  32'h0,     0, 0, 5, 3, 32'h22,       32'hDEADBEEF, 32'h22, 32'hDEADBEEF, 0, 0};
    vecs[5]  = '{1, 4, 32'hAAAA,     1, 6,  32'hBBBB,  0, 0, 4, 6, 32'hAAAA,     32'hBBBB,     32'h0, 32'h0,        0, 0};
    vecs[6]  = '{0, 0, 32'h0,        0, 0,  32'h0,     0, 0, 4, 6, 32'hAAAA,     32'hBBBB,     32'hAAAA, 32'hBBBB,  0, 0};
    vecs[7]  = '{0, 0, 32'h0,        0, 0,  32'h0,     1, 7, 7, 7, 32'h0,        32'h0,        32'h0, 32'h0,        0, 0};
    vecs[8]  = '{1, 7, 32'h77,       0, 0,  32'h0,     1, 7, 0, 7, 32'h0,        32'h77,       32'h0, 32'h0,        0, 1};
    vecs[9]  = '{0, 0, 32'h0,        1, 7,  32'h78,    0, 0, 0, 7, 32'h0,        32'h78,       32'h0, 32'h77,       0, 1};
    vecs[10] = '{0, 0, 32'h0,        0, 0,  32'h0,     1, 8, 8, 7, 32'h0,        32'h78,       32'h0, 32'h78,       0, 0};
    vecs[11] = '{0, 0, 32'h0,        0, 0,  32'h0,     1, 0, 8, 7, 32'h0,        32'h78,       32'h0, 32'h78,       1, 0};

    // Power-on reset
    RST_N = 1'b0;
    clear_in();
    ra0 = 5'd3;
    ra1 = 5'd0;
    #8;
    chk("reset_rd0", rd0_b, 32'h0);
    chk("reset_clr_busy", 32'(clrb_b), 32'h0);
    chk("reset_busy0", 32'(busy0_b), 32'h0);
    #4 RST_N = 1'b1;
    tick();

    // Single-cycle vectors
    for (int v = 0; v < 12; v++) begin
      we0 = vecs[v].we0; wa0 = vecs[v].wa0; wd0 = vecs[v].wd0;
      we1 = vecs[v].we1; wa1 = vecs[v].wa1; wd1 = vecs[v].wd1;
      iss_en = vecs[v].iss; iss_ra = vecs[v].isa; clr_req = 1'b0;
      ra0 = vecs[v].ra0; ra1 = vecs[v].ra1;
      #3;
      chk($sformatf("vec%0d_rd0", v), rd0_b, vecs[v].e_rd0);
      chk($sformatf("vec%0d_rd1", v), rd1_b, vecs[v].e_rd1);
      chk($sformatf("vec%0d_rd0_nobyp", v), rd0_n, vecs[v].e_rd0n);
      chk($sformatf("vec%0d_rd1_nobyp", v), rd1_n, vecs[v].e_rd1n);
      chk($sformatf("vec%0d_busy0", v), 32'(busy0_b), 32'(vecs[v].e_b0));
      chk($sformatf("vec%0d_busy1", v), 32'(busy1_b), 32'(vecs[v].e_b1));
      chk($sformatf("vec%0d_busy1_nobyp", v), 32'(busy1_n), 32'(vecs[v].e_b1));
      tick();
    end

    // Async reset between edges clears array and scoreboard at once
    clear_in();
    iss_en = 1'b1; iss_ra = 5'd3; ra0 = 5'd3; ra1 = 5'd0;
    tick();
    clear_in();
    #3;
    chk("pre_rst_rd0", rd0_b, 32'hDEADBEEF);
    chk("pre_rst_busy0", 32'(busy0_b), 32'h1);
    RST_N = 1'b0;
    #1;
    chk("async_rst_rd0", rd0_b, 32'h0);
    chk("async_rst_rd0_nobyp", rd0_n, 32'h0);
    chk("async_rst_busy0", 32'(busy0_b), 32'h0);
    chk("async_rst_clr_busy", 32'(clrb_b), 32'h0);
    #2 RST_N = 1'b1;
    tick();

    // Clear sweep: fill r1..r15 and mark each busy in the same cycle
    for (int i = 1; i < 16; i++) begin
      clear_in();
      we0 = 1'b1; wa0 = 5'(i); wd0 = 32'(i) * 32'h100;
      iss_en = 1'b1; iss_ra = 5'(i);
      tick();
    end
    clear_in();
    ra0 = 5'd2; ra1 = 5'd15;
    #3;
    chk("fill_r2", rd0_b, 32'h200);
    chk("fill_busy_r15", 32'(busy1_b), 32'h1);
    clr_req = 1'b1;
    chk("clr_busy_before_edge", 32'(clrb_b), 32'h0);
    tick();
    clr_req = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      clear_in();
      ra0 = (k < 15) ? 5'(k + 1) : 5'd0;
      ra1 = 5'(k);
      if (k == 5) begin
        we0 = 1'b1; wa0 = 5'd2; wd0 = 32'hFFFF;
        we1 = 1'b1; wa1 = 5'd6; wd1 = 32'hFFFF;
        iss_en = 1'b1; iss_ra = 5'd2; clr_req = 1'b1;
      end
      #3;
      if (!clrb_b) break;
      cnt++;
      if (k < 15) begin
        chk($sformatf("sweep%0d_unswept_rd", k), rd0_b, 32'(k + 1) * 32'h100);
        chk($sformatf("sweep%0d_unswept_busy", k), 32'(busy0_b), 32'h1);
      end
      if (k >= 1 && k < 16) begin
        chk($sformatf("sweep%0d_swept_rd", k), rd1_b, 32'h0);
        chk($sformatf("sweep%0d_swept_busy", k), 32'(busy1_b), 32'h0);
      end
      tick();
    end
    chk("sweep_length", 32'(cnt), 32'd15);
    clear_in();
    for (int i = 0; i < 17; i++) begin
      ra0 = 5'(i); ra1 = 5'(i);
      #1;
      chk($sformatf("post_sweep_r%0d", i), rd0_b, 32'h0);
      chk($sformatf("post_sweep_r%0d_nobyp", i), rd1_n, 32'h0);
      chk($sformatf("post_sweep_busy%0d", i), 32'(busy1_b), 32'h0);
    end
    tick();
    #3;
    chk("no_restart_clr_busy", 32'(clrb_b), 32'h0);
    tick();

    // Reset during a sweep aborts it
    clear_in();
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h5555;
    we1 = 1'b1; wa1 = 5'd10; wd1 = 32'hAAAA;
    tick();
    clear_in();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    ra0 = 5'd10; ra1 = 5'd5;
    #2;
    chk("mid_sweep_clr_busy", 32'(clrb_b), 32'h1);
    chk("mid_sweep_r10", rd0_b, 32'hAAAA);
    RST_N = 1'b0;
    #1;
    chk("sweep_rst_clr_busy", 32'(clrb_b), 32'h0);
    chk("sweep_rst_clr_busy_nobyp", 32'(clrb_n), 32'h0);
    chk("sweep_rst_r10", rd0_b, 32'h0);
    chk("sweep_rst_r5", rd1_b, 32'h0);
    #2 RST_N = 1'b1;
    tick();
    #3;
    chk("after_rst_clr_busy", 32'(clrb_b), 32'h0);
    tick();
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h9;
    tick();
    clear_in();
    ra0 = 5'd9;
    #3;
    chk("after_rst_write_r9", rd0_b, 32'h9);
    chk("after_rst_write_r9_nobyp", rd0_n, 32'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
